interconnect_req_arbiter: RTL

Two-requester arbiter that shares the interconnect's single downstream request/response channel between the SPI-side adapter (requester 0) and the Wishbone-side port (requester 1). It grants requests round-robin and records the winner of each grant in an in-order tag FIFO. Each downstream response is routed back to the requester that issued it. It sits between the SPI minion adapter / Wishbone bridge and the interconnect crossbar.

---
 rtl/interconnect_arb_pkg.sv | 17 +
 rtl/interconnect_arb_tag_fifo.sv | 57 +++++
 rtl/interconnect_req_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/interconnect_arb_pkg.sv
// rtl/interconnect_arb_pkg.sv - shared message types and requester IDs for the request arbiter
package interconnect_arb_pkg;

   localparam int ARB_ADDR_W = 4;
   localparam int ARB_DATA_W = 16;

   typedef struct packed {
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] data;
   } req_msg_t;

   typedef logic [ARB_DATA_W-1:0] resp_msg_t;

   localparam logic REQ_SPI = 1'b0;
   localparam logic REQ_WB  = 1'b1;

endpackage

// File: rtl/interconnect_arb_tag_fifo.sv
// rtl/interconnect_arb_tag_fifo.sv - in-order FIFO of 1-bit requester tags for outstanding requests
module interconnect_arb_tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         push_id,
   input  logic                         pop,
   output logic                         head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses pushes even when a pop lands in the same cycle,
   // so the grant path never depends on the response handshake.
   assign full    = (count == CNT_MAX);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Tag storage, wrapping pointers and occupancy; reset drops every tag at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_id;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (!do_push && do_pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/interconnect_req_arbiter.sv
// rtl/interconnect_req_arbiter.sv - round-robin arbiter sharing one downstream channel between SPI and Wishbone requesters
module interconnect_req_arbiter
   import interconnect_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req0_val,
   output logic                       req0_rdy,
   input  logic [ADDR_W+DATA_W-1:0]   req0_msg,
   input  logic                       req1_val,
   output logic                       req1_rdy,
   input  logic [ADDR_W+DATA_W-1:0]   req1_msg,
   output logic                       dn_req_val,
   input  logic                       dn_req_rdy,
   output logic [ADDR_W+DATA_W-1:0]   dn_req_msg,
   input  logic                       dn_resp_val,
   output logic                       dn_resp_rdy,
   input  logic [DATA_W-1:0]          dn_resp_msg,
   output logic                       resp0_val,
   input  logic                       resp0_rdy,
   output logic [DATA_W-1:0]          resp0_msg,
   output logic                       resp1_val,
   input  logic                       resp1_rdy,
   output logic [DATA_W-1:0]          resp1_msg,
   output logic [$clog2(DEPTH+1)-1:0] outstanding
);

   logic prio;
   logic winner;
   logic can_grant;
   logic grant_fire;
   logic resp_fire;
   logic head_rdy;
   logic tag_head;
   logic tag_full;
   logic tag_empty;

   // Pick the sole valid requester, or the one named by prio when both are valid.
   always_comb begin
      winner = REQ_SPI;
      if (req0_val && req1_val) begin
         winner = prio;
      end else if (req1_val) begin
         winner = REQ_WB;
      end
   end

   // Reset is folded in so every handshake output stays low while reset is held.
   assign can_grant  = reset & dn_req_rdy & ~tag_full;
   assign grant_fire = can_grant & (req0_val | req1_val);

   assign dn_req_val = grant_fire;
   assign dn_req_msg = (winner == REQ_WB) ? req1_msg : req0_msg;
   assign req0_rdy   = can_grant & (winner == REQ_SPI);
   assign req1_rdy   = can_grant & (winner == REQ_WB);

   // Responses follow the oldest tag; with no tag a response is simply not accepted.
   assign head_rdy    = (tag_head == REQ_WB) ? resp1_rdy : resp0_rdy;
   assign dn_resp_rdy = reset & ~tag_empty & head_rdy;
   assign resp0_val   = reset & dn_resp_val & ~tag_empty & (tag_head == REQ_SPI);
   assign resp1_val   = reset & dn_resp_val & ~tag_empty & (tag_head == REQ_WB);
   assign resp0_msg   = dn_resp_msg;
   assign resp1_msg   = dn_resp_msg;
   assign resp_fire   = dn_resp_val & dn_resp_rdy;

   // Priority pointer hands the next tie to the requester that just lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio <= REQ_SPI;
      end else if (grant_fire) begin
         prio <= ~winner;
      end
   end

   interconnect_arb_tag_fifo #(
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (grant_fire),
      .push_id (winner),
      .pop     (resp_fire),
      .head    (tag_head),
      .full    (tag_full),
      .empty   (tag_empty),
      .count   (outstanding)
   );

endmodule
